// File: rtl/dmac_engine.sv
// dmac_engine: single-channel memory-to-memory copy engine on AXI.
// Each word moves as one single-beat read followed by one single-beat write.
module dmac_engine (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [31:0] src_addr_i,
  input  logic [31:0] dst_addr_i,
  input  logic [15:0] byte_len_i,
  output logic        done_o,
  output logic [31:0] araddr_o,
  output logic        arvalid_o,
  input  logic        arready_i,
  input  logic [31:0] rdata_i,
  input  logic        rvalid_i,
  output logic        rready_o,
  output logic [31:0] awaddr_o,
  output logic        awvalid_o,
  input  logic        awready_i,
  output logic [31:0] wdata_o,
  output logic        wvalid_o,
  input  logic        wready_i,
  input  logic        bvalid_i,
  output logic        bready_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RREQ  = 3'd1,
    RDATA = 3'd2,
    WREQ  = 3'd3,
    WRESP = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] src_q, src_d;
  logic [31:0] dst_q, dst_d;
  logic [31:0] buf_q, buf_d;
  logic [15:0] cnt_q, cnt_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [15:0] len_word_s;

  // Masking keeps all length bits in the expression while dropping the byte remainder.
  assign len_word_s = byte_len_i & 16'hFFFC;

  // State, address, count and data registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      src_q     <= 32'd0;
      dst_q     <= 32'd0;
      buf_q     <= 32'd0;
      cnt_q     <= 16'd0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      buf_q     <= buf_d;
      cnt_q     <= cnt_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    buf_d     = buf_q;
    cnt_d     = cnt_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          src_d = src_addr_i;
          dst_d = dst_addr_i;
          cnt_d = len_word_s;
          if (len_word_s != 16'd0) begin
            state_d = RREQ;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RREQ: begin
        if (arready_i) begin
          state_d = RDATA;
        end else begin
          state_d = RREQ;
        end
      end
      RDATA: begin
        if (rvalid_i) begin
          buf_d     = rdata_i;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = WREQ;
        end else begin
          state_d = RDATA;
        end
      end
      WREQ: begin
        // A set done flag masks its valid, so ready alone marks the handshake.
        aw_done_d = aw_done_q | awready_i;
        w_done_d  = w_done_q | wready_i;
        if (aw_done_d && w_done_d) begin
          state_d = WRESP;
        end else begin
          state_d = WREQ;
        end
      end
      WRESP: begin
        if (bvalid_i) begin
          src_d = src_q + 32'd4;
          dst_d = dst_q + 32'd4;
          cnt_d = cnt_q - 16'd4;
          if (cnt_q == 16'd4) begin
            state_d = IDLE;
          end else begin
            state_d = RREQ;
          end
        end else begin
          state_d = WRESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign done_o    = (state_q == IDLE);
  assign arvalid_o = (state_q == RREQ);
  assign araddr_o  = src_q;
  assign rready_o  = (state_q == RDATA);
  assign awvalid_o = (state_q == WREQ) && !aw_done_q;
  assign awaddr_o  = dst_q;
  assign wvalid_o  = (state_q == WREQ) && !w_done_q;
  assign wdata_o   = buf_q;
  assign bready_o  = (state_q == WRESP);

endmodule

// File: tb/tb_dmac_engine.sv
// Table-driven bench for dmac_engine: a small AXI responder with directed
// stall patterns, plus a hand-written start-ignore / mid-transfer reset sequence.
module tb_dmac_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [31:0] src_addr_i, dst_addr_i;
  logic [15:0] byte_len_i;
  logic        done_o;
  logic [31:0] araddr_o;
  logic        arvalid_o, arready_i;
  logic [31:0] rdata_i;
  logic        rvalid_i, rready_o;
  logic [31:0] awaddr_o;
  logic        awvalid_o, awready_i;
  logic [31:0] wdata_o;
  logic        wvalid_o, wready_i;
  logic        bvalid_i, bready_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
    logic        stall;
    logic [7:0]  beats;
    logic [31:0] last_ra;
  } vec_t;

  vec_t vecs[6];

  dmac_engine dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .src_addr_i (src_addr_i),
    .dst_addr_i (dst_addr_i),
    .byte_len_i (byte_len_i),
    .done_o     (done_o),
    .araddr_o   (araddr_o),
    .arvalid_o  (arvalid_o),
    .arready_i  (arready_i),
    .rdata_i    (rdata_i),
    .rvalid_i   (rvalid_i),
    .rready_o   (rready_o),
    .awaddr_o   (awaddr_o),
    .awvalid_o  (awvalid_o),
    .awready_i  (awready_i),
    .wdata_o    (wdata_o),
    .wvalid_o   (wvalid_o),
    .wready_i   (wready_i),
    .bvalid_i   (bvalid_i),
    .bready_o   (bready_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle_quiet(input string name);
    chk({name, "_done"}, {31'd0, done_o}, 32'd1);
    chk({name, "_arvalid"}, {31'd0, arvalid_o}, 32'd0);
    chk({name, "_awvalid"}, {31'd0, awvalid_o}, 32'd0);
    chk({name, "_wvalid"}, {31'd0, wvalid_o}, 32'd0);
  endtask

  // One word: read address, read data, write address/data, write response.
  task automatic do_beat(input logic [31:0] ra, input logic [31:0] wa,
                         input int s_ar, input int s_r, input int s_aw,
                         input int s_w, input int s_b);
    int t;
    bit ad;
    bit wd;
    chk("arvalid", {31'd0, arvalid_o}, 32'd1);
    chk("araddr", araddr_o, ra);
    for (int k = 0; k < s_ar; k++) begin
      @(negedge clk);
      chk("arvalid_hold", {31'd0, arvalid_o}, 32'd1);
      chk("araddr_hold", araddr_o, ra);
    end
    arready_i = 1'b1;
    @(negedge clk);
    arready_i = 1'b0;
    chk("arvalid_drop", {31'd0, arvalid_o}, 32'd0);
    chk("rready", {31'd0, rready_o}, 32'd1);
    for (int k = 0; k < s_r; k++) begin
      @(negedge clk);
      chk("rready_hold", {31'd0, rready_o}, 32'd1);
    end
    rvalid_i = 1'b1;
    rdata_i  = pat(ra);
    @(negedge clk);
    rvalid_i = 1'b0;
    rdata_i  = 32'hDEAD_BEEF;
    t  = 0;
    ad = 1'b0;
    wd = 1'b0;
    while (!(ad && wd) && t < 20) begin
      chk("awvalid", {31'd0, awvalid_o}, {31'd0, !ad});
      chk("wvalid", {31'd0, wvalid_o}, {31'd0, !wd});
      if (!ad) chk("awaddr", awaddr_o, wa);
      if (!wd) chk("wdata", wdata_o, pat(ra));
      awready_i = (t >= s_aw) ? 1'b1 : 1'b0;
      wready_i  = (t >= s_w) ? 1'b1 : 1'b0;
      @(negedge clk);
      if (awready_i) ad = 1'b1;
      if (wready_i) wd = 1'b1;
      t++;
    end
    awready_i = 1'b0;
    wready_i  = 1'b0;
    chk("bready", {31'd0, bready_o}, 32'd1);
    chk("aw_w_idle", {30'd0, awvalid_o, wvalid_o}, 32'd0);
    for (int k = 0; k < s_b; k++) begin
      @(negedge clk);
      chk("bready_hold", {31'd0, bready_o}, 32'd1);
    end
    bvalid_i = 1'b1;
    @(negedge clk);
    bvalid_i = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    logic [31:0] ra;
    logic [31:0] wa;
    @(negedge clk);
    chk("pre_done", {31'd0, done_o}, 32'd1);
    src_addr_i = v.src;
    dst_addr_i = v.dst;
    byte_len_i = v.len;
    start_i    = 1'b1;
    @(negedge clk);
    start_i    = 1'b0;
    src_addr_i = 32'hBAD0_BAD0;
    dst_addr_i = 32'h0BAD_0BAD;
    byte_len_i = 16'hFFFF;
    if (v.beats == 8'd0) begin
      for (int k = 0; k < 4; k++) begin
        chk_idle_quiet("zero_len");
        @(negedge clk);
      end
    end else begin
      chk("done_drop", {31'd0, done_o}, 32'd0);
      for (int i = 0; i < int'(v.beats); i++) begin
        ra = v.src + 32'(i) * 32'd4;
        wa = v.dst + 32'(i) * 32'd4;
        if (i == int'(v.beats) - 1) chk("last_raddr", araddr_o, v.last_ra);
        if (v.stall)
          do_beat(ra, wa, (i * 2 + 1) % 6, (5 - i) % 6, (i % 3) * 2, ((i + 1) % 2) * 3, (i * 3) % 6);
        else
          do_beat(ra, wa, 0, 0, 0, 0, 0);
      end
      chk_idle_quiet("xfer_end");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{src: 32'h0000_1000, dst: 32'h0000_2000, len: 16'd16, stall: 1'b0, beats: 8'd4, last_ra: 32'h0000_100C};
    vecs[1] = '{src: 32'h0000_0000, dst: 32'h0000_3000, len: 16'd0,  stall: 1'b0, beats: 8'd0, last_ra: 32'h0000_0000};
    vecs[2] = '{src: 32'h0000_0500, dst: 32'h0000_0600, len: 16'd3,  stall: 1'b0, beats: 8'd0, last_ra: 32'h0000_0000};
    vecs[3] = '{src: 32'h0000_4000, dst: 32'h0000_8000, len: 16'd23, stall: 1'b1, beats: 8'd5, last_ra: 32'h0000_4010};
    vecs[4] = '{src: 32'hFFFF_FFF8, dst: 32'h0000_0100, len: 16'd16, stall: 1'b0, beats: 8'd4, last_ra: 32'h0000_0004};
    vecs[5] = '{src: 32'h0000_0010, dst: 32'hFFFF_FFFC, len: 16'd8,  stall: 1'b1, beats: 8'd2, last_ra: 32'h0000_0014};

    rst_n = 1'b0;
    start_i = 1'b0;
    src_addr_i = 32'd0;
    dst_addr_i = 32'd0;
    byte_len_i = 16'd0;
    arready_i = 1'b0;
    rdata_i = 32'd0;
    rvalid_i = 1'b0;
    awready_i = 1'b0;
    wready_i = 1'b0;
    bvalid_i = 1'b0;

    repeat (2) @(negedge clk);
    chk_idle_quiet("reset");
    chk("reset_rready", {31'd0, rready_o}, 32'd0);
    chk("reset_bready", {31'd0, bready_o}, 32'd0);
    chk("reset_araddr", araddr_o, 32'd0);
    chk("reset_wdata", wdata_o, 32'd0);
    rst_n = 1'b1;

    for (int v = 0; v < 6; v++) run_vec(vecs[v]);

    // Start during RDATA is ignored, then reset lands in WREQ.
    @(negedge clk);
    src_addr_i = 32'h0000_7000;
    dst_addr_i = 32'h0000_9000;
    byte_len_i = 16'd8;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("seq_arvalid", {31'd0, arvalid_o}, 32'd1);
    arready_i = 1'b1;
    @(negedge clk);
    arready_i = 1'b0;
    chk("seq_rready", {31'd0, rready_o}, 32'd1);
    src_addr_i = 32'hAAAA_0000;
    dst_addr_i = 32'hBBBB_0000;
    byte_len_i = 16'd64;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("seq_rdata_hold", {31'd0, rready_o}, 32'd1);
    chk("seq_no_restart", {30'd0, arvalid_o, done_o}, 32'd0);
    rvalid_i = 1'b1;
    rdata_i = pat(32'h0000_7000);
    @(negedge clk);
    rvalid_i = 1'b0;
    chk("seq_awvalid", {31'd0, awvalid_o}, 32'd1);
    chk("seq_awaddr", awaddr_o, 32'h0000_9000);
    chk("seq_wdata", wdata_o, pat(32'h0000_7000));
    #2 rst_n = 1'b0;
    #1;
    chk_idle_quiet("async_rst");
    chk("async_rst_bready", {31'd0, bready_o}, 32'd0);
    chk("async_rst_awaddr", awaddr_o, 32'd0);
    chk("async_rst_wdata", wdata_o, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk_idle_quiet("post_rst");
    end
    run_vec(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmac_engine.md
DMAC_ENGINE -- requirements
Module: dmac_engine

Interface
REQ-001 SHALL have no parameters; data width fixed at 32 bits, one 4-byte word per transfer.
REQ-002 SHALL use one clock and an asynchronous, active-low reset, on the ports clk and rst_n.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start_i  input  1  one-cycle start pulse from the configuration block.
REQ-006 src_addr_i  input  32  source byte address.
REQ-007 dst_addr_i  input  32  destination byte address.
REQ-008 byte_len_i  input  16  transfer length in bytes.
REQ-009 done_o  output  1  1 = engine idle, ready for a new start.
REQ-010 araddr_o  output  32  AXI read address.
REQ-011 arvalid_o  output  1  AXI read address valid.
REQ-012 arready_i  input  1  AXI read address ready.
REQ-013 rdata_i  input  32  AXI read data.
REQ-014 rvalid_i  input  1  AXI read data valid.
REQ-015 rready_o  output  1  AXI read data ready.
REQ-016 awaddr_o  output  32  AXI write address.
REQ-017 awvalid_o  output  1  AXI write address valid.
REQ-018 awready_i  input  1  AXI write address ready.
REQ-019 wdata_o  output  32  AXI write data.
REQ-020 wvalid_o  output  1  AXI write data valid.
REQ-021 wready_i  input  1  AXI write data ready.
REQ-022 bvalid_i  input  1  AXI write response valid.
REQ-023 bready_o  output  1  AXI write response ready.

Function
REQ-024 SHALL issue single-beat transactions only; the interconnect wrapper ties LEN=0, SIZE=4 B, BURST=INCR, WSTRB=4'hF, WLAST=1; RRESP and BRESP are ignored.
REQ-025 SHALL implement states IDLE, RREQ, RDATA, WREQ and WRESP, with done_o=1 only in IDLE.
REQ-026 In IDLE, start_i=1 SHALL latch src, dst and cnt = {byte_len_i[15:2],2'b00}; the engine SHALL go to RREQ if cnt!=0 and SHALL stay in IDLE otherwise.
REQ-027 In RREQ, the engine SHALL drive arvalid_o=1 and araddr_o=src, and SHALL go to RDATA on arready_i.
REQ-028 In RDATA, the engine SHALL drive rready_o=1; on rvalid_i it SHALL capture rdata_i into a 32-bit data buffer and go to WREQ.
REQ-029 In WREQ, awvalid_o (awaddr_o=dst) and wvalid_o (wdata_o=buffer) SHALL assert together.
REQ-030 In WREQ, each of awvalid_o and wvalid_o SHALL drop independently after its own handshake; the engine SHALL go to WRESP once both handshakes are complete, including when both complete in the same cycle.
REQ-031 In WRESP, the engine SHALL drive bready_o=1; on bvalid_i it SHALL set src+=4, dst+=4 and cnt-=4, then go to IDLE if the old cnt==4 and to RREQ otherwise.
REQ-032 Address arithmetic SHALL be 32-bit modulo 2^32 (wrap from 0xFFFF_FFFC to 0x0).
REQ-033 byte_len_i[1:0] SHALL be ignored; no address alignment check SHALL be performed.
REQ-034 A valid signal SHALL stay high with stable address/data until its handshake completes.
REQ-035 start_i outside IDLE SHALL be ignored.
REQ-036 Changes on src_addr_i, dst_addr_i or byte_len_i after start SHALL have no effect on the running transfer.
REQ-037 All outputs SHALL be registered or decoded from state only; arvalid_o SHALL assert the cycle after start_i, and done_o SHALL deassert the cycle after start_i.

Reset
REQ-038 While rst_n=0, the engine SHALL hold state=IDLE, done_o=1 and all valid/ready outputs at 0, and SHALL clear all address, count and data registers to 0.
REQ-039 Reset asserted mid-transfer SHALL abandon the transfer immediately, with no further AXI requests after release.

Verification
REQ-040 src=0x1000, dst=0x2000, len=16, zero-wait memory -> 4 reads from 0x1000..0x100C, 4 writes to 0x2000..0x200C with matching data, then done_o=1.
REQ-041 len=0 and len=3 -> no AXI activity, and done_o stays 1.
REQ-042 arready, rvalid, awready, wready and bvalid with random 0-5 cycle stalls, awready before wready and vice versa -> data intact and valid signals never drop early.
REQ-043 src=0xFFFF_FFF8, len=16 -> read addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0, 0x4.
REQ-044 start_i pulsed during RDATA, then rst_n pulsed low during WREQ -> the second start is ignored, outputs return to reset values asynchronously, and a new transfer after reset completes correctly.
